key_scan: RTL

//  Memory-mapped 4x4 matrix keypad input device; the input counterpart of the 7-seg output device.

---
 rtl/key_scan_pkg.sv | 29 ++
 rtl/key_fifo.sv | 53 +++++
 rtl/key_scan.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and constants for the key_scan keypad device: FSM states, Dout layout, idle patterns.
package key_scan_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int unsigned VALID_BIT = 31;
  localparam int unsigned OVF_BIT   = 30;
  localparam int unsigned LVL_MSB   = 29;
  localparam int unsigned LVL_LSB   = 27;
  localparam int unsigned LVL_W     = LVL_MSB - LVL_LSB + 1;
  localparam int unsigned CODE_W    = 4;

  localparam logic [3:0] ROW_IDLE = 4'b1110;
  localparam logic [3:0] COL_NONE = 4'b1111;

  // Index of the lowest active-low bit; 0 when none is low.
  function automatic logic [1:0] low_idx(input logic [3:0] v_n);
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v_n[i]) low_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Circular key-code queue with a registered head and fill level (used when KEY_FIFO_EN is defined).
module key_fifo
  import key_scan_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] head,
  output logic [LVL_W-1:0]  level,
  output logic              full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full = (level == LVL_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Head is kept in its own flop so the read port is a register, not a memory mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      level <= level + LVL_W'(push) - LVL_W'(pop);
      if (push && ((level == '0) || ((level == LVL_W'(1)) && pop)))
        head <= din;
      else if (pop && (level > LVL_W'(1)))
        head <= mem[ptr_inc(rd_ptr)];
      else if (pop)
        head <= '0;
    end
  end

endmodule

// File: rtl/key_scan.sv
// Memory-mapped 4x4 keypad scanner with debounce and key queue.
// Define KEY_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Re,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic [3:0]  key_row_n,
  input  logic [3:0]  key_col_n
);

  localparam int unsigned SCAN_COUNT = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W      = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int unsigned DEB_W      = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [3:0]        col_m, col_s;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick_c;
  state_t            state_q, state_d;
  logic [CODE_W-1:0] cand_q, code_c;
  logic [DEB_W-1:0]  deb_q;
  logic              none_c, match_c, deb_zero_c;
  logic              adv_row_c, load_cand_c, load_deb_c, dec_deb_c, push_c;
  logic              pop_c, full_c, valid_c, ovf_q;
  logic [CODE_W-1:0] head;
  logic [LVL_W-1:0]  level;
  logic              unused_din;

  assign unused_din = ^{Din[31], Din[29:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      col_m <= COL_NONE;
      col_s <= COL_NONE;
    end else begin
      col_m <= key_col_n;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || tick_c) tick_cnt <= CNT_W'(SCAN_COUNT - 1);
    else               tick_cnt <= tick_cnt - CNT_W'(1);
  end
  assign tick_c = (tick_cnt == '0);

  assign code_c     = {low_idx(key_row_n), low_idx(col_s)};
  assign none_c     = (col_s == COL_NONE);
  assign match_c    = !none_c && (code_c == cand_q);
  assign deb_zero_c = (deb_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick_c) begin
      unique case (state_q)
        IDLE:     if (!none_c) state_d = DEBOUNCE;
        DEBOUNCE: if (!match_c) state_d = IDLE;
                  else if (deb_zero_c) state_d = HELD;
        HELD:     if (none_c) state_d = RELEASE;
        RELEASE:  if (!none_c) state_d = HELD;
                  else if (deb_zero_c) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    adv_row_c   = 1'b0;
    load_cand_c = 1'b0;
    load_deb_c  = 1'b0;
    dec_deb_c   = 1'b0;
    push_c      = 1'b0;
    if (tick_c) begin
      unique case (state_q)
        IDLE: begin
          adv_row_c   = none_c;
          load_cand_c = !none_c;
          load_deb_c  = !none_c;
        end
        DEBOUNCE: begin
          push_c    = match_c && deb_zero_c;
          dec_deb_c = match_c && !deb_zero_c;
        end
        HELD:    load_deb_c = none_c;
        RELEASE: dec_deb_c  = none_c && !deb_zero_c;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_row_n <= ROW_IDLE;
      cand_q    <= '0;
      deb_q     <= '0;
    end else begin
      if (adv_row_c)   key_row_n <= {key_row_n[2:0], key_row_n[3]};
      if (load_cand_c) cand_q <= code_c;
      if (load_deb_c)      deb_q <= DEB_W'(DEBOUNCE_TICKS - 1);
      else if (dec_deb_c)  deb_q <= deb_q - DEB_W'(1);
    end
  end

  assign valid_c = (level != '0);
  assign pop_c   = Re && valid_c;

`ifdef KEY_FIFO_EN
  logic push_ok_c;
  assign push_ok_c = push_c && (!full_c || pop_c);

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok_c),
    .pop   (pop_c),
    .din   (cand_q),
    .head  (head),
    .level (level),
    .full  (full_c)
  );
`else
  localparam int unsigned unused_fifo_depth = FIFO_DEPTH;
  logic valid_q;

  // Single-entry holding register; a same-cycle pop makes room for the new key.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      head    <= '0;
    end else if (push_c && (!valid_q || pop_c)) begin
      valid_q <= 1'b1;
      head    <= cand_q;
    end else if (pop_c) begin
      valid_q <= 1'b0;
      head    <= '0;
    end
  end
  assign level  = LVL_W'(valid_q);
  assign full_c = valid_q;
`endif

  // Overflow is sticky; a same-cycle set beats the CPU clear.
  always_ff @(posedge clk) begin
    if (rst)                               ovf_q <= 1'b0;
    else if (push_c && full_c && !pop_c)   ovf_q <= 1'b1;
    else if (We && Din[OVF_BIT])           ovf_q <= 1'b0;
  end

  always_comb begin
    Dout                   = '0;
    Dout[VALID_BIT]        = valid_c;
    Dout[OVF_BIT]          = ovf_q;
    Dout[LVL_MSB:LVL_LSB]  = level;
    Dout[CODE_W-1:0]       = head;
  end

endmodule
